// File: rtl/inst_fetcher_pkg.sv
// Shared definitions for the instruction fetcher: widths, boolean constants,
// fetcher state encodings and PC helpers.
package inst_fetcher_pkg;

    localparam int ADDRESS_WIDTH     = 32;
    localparam int INSTRUCTION_WIDTH = 32;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [1:0] FETCH_IDLE     = 2'd0;
    localparam logic [1:0] FETCH_WAIT_MEM = 2'd1;
    localparam logic [1:0] FETCH_HOLD     = 2'd2;
    localparam logic [1:0] FETCH_DISCARD  = 2'd3;

    // Redirect targets may carry junk in the byte-offset bits.
    function automatic logic [ADDRESS_WIDTH-1:0] word_align(
        input logic [ADDRESS_WIDTH-1:0] addr
    );
        return addr & ~ADDRESS_WIDTH'(3);
    endfunction

    function automatic logic [ADDRESS_WIDTH-1:0] next_pc(
        input logic [ADDRESS_WIDTH-1:0] pc
    );
        return pc + ADDRESS_WIDTH'(4);
    endfunction

endpackage

// File: rtl/inst_fetcher_icache.sv
// Direct-mapped, one-word-per-line instruction cache for the fetcher.
// Combinational lookup, synchronous fill, valid bits cleared asynchronously on reset.
module inst_fetcher_icache
    import inst_fetcher_pkg::*;
#(
    parameter int ICACHE_INDEX = 8
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [ADDRESS_WIDTH-1:0]     lookup_addr_i,
    output logic                         hit_o,
    output logic [INSTRUCTION_WIDTH-1:0] data_o,
    input  logic                         fill_en_i,
    input  logic [ADDRESS_WIDTH-1:0]     fill_addr_i,
    input  logic [INSTRUCTION_WIDTH-1:0] fill_data_i
);

    localparam int LINES = 1 << ICACHE_INDEX;
    localparam int TAG_W = ADDRESS_WIDTH - ICACHE_INDEX - 2;

    logic [LINES-1:0]             valid_q;
    logic [TAG_W-1:0]             tag_q  [LINES];
    logic [INSTRUCTION_WIDTH-1:0] line_q [LINES];

    logic [ICACHE_INDEX-1:0] look_idx;
    logic [TAG_W-1:0]        look_tag;
    logic [ICACHE_INDEX-1:0] fill_idx;
    logic [TAG_W-1:0]        fill_tag;
    logic                    fill_ok;

    assign look_idx = lookup_addr_i[ICACHE_INDEX+1:2];
    assign look_tag = lookup_addr_i[ADDRESS_WIDTH-1:ICACHE_INDEX+2];
    assign fill_idx = fill_addr_i[ICACHE_INDEX+1:2];
    assign fill_tag = fill_addr_i[ADDRESS_WIDTH-1:ICACHE_INDEX+2];

    // Only word-aligned addresses ever reach the cache; misaligned ones never hit or fill.
    assign fill_ok = fill_en_i && (fill_addr_i[1:0] == 2'b00);
    assign hit_o   = valid_q[look_idx] && (tag_q[look_idx] == look_tag)
                     && (lookup_addr_i[1:0] == 2'b00);
    assign data_o  = line_q[look_idx];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_q <= '0;
        end else if (fill_ok) begin
            valid_q[fill_idx] <= TRUE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (fill_ok) begin
            tag_q[fill_idx]  <= fill_tag;
            line_q[fill_idx] <= fill_data_i;
        end
    end

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetcher: keeps the PC, fetches words from memory (predict not-taken),
// holds one instruction for the decoder and redirects on flush. Optional icache: ICACHE_EN.
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0,
    parameter int          ICACHE_INDEX = 8
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         rdy_in,
    input  logic                         in_stall,
    input  logic                         in_clear,
    input  logic [ADDRESS_WIDTH-1:0]     in_clear_pc,
    output logic [INSTRUCTION_WIDTH-1:0] out_inst,
    output logic [ADDRESS_WIDTH-1:0]     out_pc,
    output logic                         out_fetch_valid,
    output logic                         out_mem_req,
    output logic [ADDRESS_WIDTH-1:0]     out_mem_addr,
    input  logic                         in_mem_valid,
    input  logic [INSTRUCTION_WIDTH-1:0] in_mem_inst
);

    if (ICACHE_INDEX < 1 || ICACHE_INDEX > 28) begin : g_bad_index
        $error("inst_fetcher: ICACHE_INDEX out of range");
    end

    logic [1:0]                   state_q,       state_d;
    logic [ADDRESS_WIDTH-1:0]     pc_q,          pc_d;
    logic [INSTRUCTION_WIDTH-1:0] inst_q,        inst_d;
    logic [ADDRESS_WIDTH-1:0]     out_pc_q,      out_pc_d;
    logic                         fetch_valid_q, fetch_valid_d;
    logic                         mem_req_q,     mem_req_d;
    logic [ADDRESS_WIDTH-1:0]     mem_addr_q,    mem_addr_d;

    logic [ADDRESS_WIDTH-1:0]     pc_plus4;
    logic                         cache_hit;
    logic [INSTRUCTION_WIDTH-1:0] cache_line;

    assign pc_plus4 = next_pc(pc_q);

`ifdef ICACHE_EN
    logic [ADDRESS_WIDTH-1:0] lookup_addr;
    logic                     fill_en;

    // In HOLD the lookup is for the successor so an accept can chain straight into it.
    assign lookup_addr = (state_q == FETCH_HOLD) ? pc_plus4 : pc_q;
    assign fill_en     = rdy_in && mem_req_q && in_mem_valid;

    inst_fetcher_icache #(
        .ICACHE_INDEX (ICACHE_INDEX)
    ) u_icache (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .lookup_addr_i (lookup_addr),
        .hit_o         (cache_hit),
        .data_o        (cache_line),
        .fill_en_i     (fill_en),
        .fill_addr_i   (mem_addr_q),
        .fill_data_i   (in_mem_inst)
    );
`else
    assign cache_hit  = FALSE;
    assign cache_line = '0;
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inst_d        = inst_q;
        out_pc_d      = out_pc_q;
        fetch_valid_d = fetch_valid_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;

        if (in_clear) begin
            fetch_valid_d = FALSE;
            pc_d          = word_align(in_clear_pc);
            case (state_q)
                FETCH_WAIT_MEM, FETCH_DISCARD: begin
                    // A response arriving with the flush is simply dropped.
                    if (in_mem_valid) begin
                        mem_req_d = FALSE;
                        state_d   = FETCH_IDLE;
                    end else begin
                        state_d   = FETCH_DISCARD;
                    end
                end
                default: state_d = FETCH_IDLE;
            endcase
        end else begin
            case (state_q)
                FETCH_IDLE: begin
                    if (cache_hit) begin
                        fetch_valid_d = TRUE;
                        inst_d        = cache_line;
                        out_pc_d      = pc_q;
                        state_d       = FETCH_HOLD;
                    end else begin
                        mem_req_d     = TRUE;
                        mem_addr_d    = pc_q;
                        state_d       = FETCH_WAIT_MEM;
                    end
                end
                FETCH_WAIT_MEM: begin
                    if (in_mem_valid) begin
                        mem_req_d     = FALSE;
                        fetch_valid_d = TRUE;
                        inst_d        = in_mem_inst;
                        out_pc_d      = pc_q;
                        state_d       = FETCH_HOLD;
                    end
                end
                FETCH_HOLD: begin
                    if (fetch_valid_q && !in_stall) begin
                        pc_d = pc_plus4;
                        if (cache_hit) begin
                            inst_d   = cache_line;
                            out_pc_d = pc_plus4;
                        end else begin
                            fetch_valid_d = FALSE;
                            state_d       = FETCH_IDLE;
                        end
                    end
                end
                default: begin
                    if (in_mem_valid) begin
                        mem_req_d = FALSE;
                        state_d   = FETCH_IDLE;
                    end
                end
            endcase
        end
    end

    // rdy_in low freezes every register, including the effect of a pending flush.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= FETCH_IDLE;
            pc_q          <= RESET_PC;
            inst_q        <= '0;
            out_pc_q      <= '0;
            fetch_valid_q <= FALSE;
            mem_req_q     <= FALSE;
            mem_addr_q    <= '0;
        end else if (rdy_in) begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inst_q        <= inst_d;
            out_pc_q      <= out_pc_d;
            fetch_valid_q <= fetch_valid_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
        end
    end

    assign out_inst        = inst_q;
    assign out_pc          = out_pc_q;
    assign out_fetch_valid = fetch_valid_q;
    assign out_mem_req     = mem_req_q;
    assign out_mem_addr    = mem_addr_q;

endmodule
